mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_arb_pick.sv | 18 +
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the icache/dcache memory arbiter.
// Holds FSM state encoding, owner encoding and default ADDR_W/DATA_W.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection between icache and dcache requests.
// Ports: i_req_i/d_req_i requests, last_d_i last-served was dcache, gnt_*_o.
module arb_pick (
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_d_i,
  output logic gnt_i_o,
  output logic gnt_d_o
);

  // On a tie dcache wins unless it was the last one served; with last_d_i
  // tied low this degenerates to fixed dcache priority.
  always_comb begin
    gnt_d_o = d_req_i & (~i_req_i | ~last_d_i);
    gnt_i_o = i_req_i & ~gnt_d_o;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main memory between icache (read-only) and dcache (read/write).
// Ports: clk, reset (async, active-low); i_* icache side; d_* dcache side;
//   m_* main memory side; owner = current grant (00 none, 01 I, 10 D).
// Macro MEM_ARB_ROUND_ROBIN_EN: tie-break toward the client not served last;
//   undefined gives fixed dcache priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_busywait,
  output logic [1:0]        owner
);

  arb_state_e        state_q;
  owner_e            owner_q;
  logic              cur_d_q;
  logic              m_read_q;
  logic              m_write_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              mbw_q;
  logic              d_req;
  logic              gnt_i;
  logic              gnt_d;
  logic              last_d;
  logic              done;

  assign d_req = d_read | d_write;
  // Falling edge of the memory busywait marks completion.
  assign done  = mbw_q & ~m_busywait;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_q;
  assign last_d = last_d_q;
`else
  assign last_d = 1'b0;
`endif

  arb_pick u_pick (
    .i_req_i  (i_read),
    .d_req_i  (d_req),
    .last_d_i (last_d),
    .gnt_i_o  (gnt_i),
    .gnt_d_o  (gnt_d)
  );

  // The command is latched at grant so a withdrawn request cannot
  // abort an access the memory has already started.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      cur_d_q   <= 1'b0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      mbw_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      mbw_q <= m_busywait;
      unique case (state_q)
        IDLE: begin
          if (gnt_d) begin
            state_q   <= GRANT_D;
            owner_q   <= OWN_D;
            cur_d_q   <= 1'b1;
            m_read_q  <= d_read & ~d_write;
            m_write_q <= d_write;
            m_addr_q  <= d_address;
            m_wdata_q <= d_writedata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q  <= 1'b1;
`endif
          end else if (gnt_i) begin
            state_q   <= GRANT_I;
            owner_q   <= OWN_I;
            cur_d_q   <= 1'b0;
            m_read_q  <= 1'b1;
            m_write_q <= 1'b0;
            m_addr_q  <= i_address;
            m_wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q  <= 1'b0;
`endif
          end
        end
        GRANT_I, GRANT_D: begin
          if (done) begin
            state_q   <= RELEASE;
            owner_q   <= OWN_NONE;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            // Writes leave the client's read data untouched.
            if (m_read_q) begin
              if (cur_d_q) d_rdata_q <= m_readdata;
              else         i_rdata_q <= m_readdata;
            end
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_read      = m_read_q;
  assign m_write     = m_write_q;
  assign m_address   = m_addr_q;
  assign m_writedata = m_wdata_q;
  assign owner       = owner_q;
  assign i_readdata  = i_rdata_q;
  assign d_readdata  = d_rdata_q;

  // Stall follows the live request, dropping only in the client's own
  // RELEASE cycle; forced low while reset is held.
  assign i_busywait = reset & i_read
                    & ~((state_q == RELEASE) & ~cur_d_q);
  assign d_busywait = reset & d_req
                    & ~((state_q == RELEASE) & cur_d_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a 5-cycle busywait memory model.
// Table-driven single-client accesses plus hand sequences for corner cases.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_read = 1'b0;
  logic [5:0]  i_address = '0;
  logic [31:0] i_readdata;
  logic        i_busywait;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [5:0]  d_address = '0;
  logic [31:0] d_writedata = '0;
  logic [31:0] d_readdata;
  logic        d_busywait;
  logic        m_read;
  logic        m_write;
  logic [5:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_busywait;
  logic [1:0]  owner;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_readdata  (i_readdata),
    .i_busywait  (i_busywait),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_writedata (d_writedata),
    .d_readdata  (d_readdata),
    .d_busywait  (d_busywait),
    .m_read      (m_read),
    .m_write     (m_write),
    .m_address   (m_address),
    .m_writedata (m_writedata),
    .m_readdata  (m_readdata),
    .m_busywait  (m_busywait),
    .owner       (owner)
  );

  // Memory: busy for 5 cycles from the first cycle a command is seen.
  logic [2:0] mcnt = '0;
  function automatic logic [31:0] mdata(input logic [5:0] a);
    return {8'h10, 2'b00, a, 2'b00, a, 2'b00, a};
  endfunction
  assign m_busywait = (m_read | m_write) && (mcnt != 3'd5);
  assign m_readdata = m_read ? mdata(m_address) : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (m_read | m_write) begin
      if (mcnt != 3'd5) mcnt <= mcnt + 3'd1;
    end else begin
      mcnt <= '0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        ir, dr, dw;
    logic [5:0]  ia, da;
    logic [31:0] dwd;
    logic [1:0]  own;
    logic        mr, mw;
    logic [5:0]  ma;
    logic [31:0] mwd;
    logic [31:0] xir, xdr;
  } vec_t;

  function automatic vec_t mk(
    input string nm, input logic ir, dr, dw,
    input logic [5:0] ia, da, input logic [31:0] dwd,
    input logic [1:0] own, input logic mr, mw,
    input logic [5:0] ma, input logic [31:0] mwd, xir, xdr);
    vec_t v;
    v.name = nm; v.ir = ir; v.dr = dr; v.dw = dw;
    v.ia = ia; v.da = da; v.dwd = dwd; v.own = own;
    v.mr = mr; v.mw = mw; v.ma = ma; v.mwd = mwd;
    v.xir = xir; v.xdr = xdr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int cnt;
    logic bw_own, bw_oth;
    @(negedge clk);
    i_read = v.ir; i_address = v.ia;
    d_read = v.dr; d_write = v.dw;
    d_address = v.da; d_writedata = v.dwd;
    @(posedge clk); #1;
    chk({v.name, ".owner"}, owner, v.own);
    chk({v.name, ".m_read"}, m_read, v.mr);
    chk({v.name, ".m_write"}, m_write, v.mw);
    chk({v.name, ".m_addr"}, m_address, v.ma);
    chk({v.name, ".m_wdata"}, m_writedata, v.mwd);
    bw_own = (v.own == 2'b01) ? i_busywait : d_busywait;
    bw_oth = (v.own == 2'b01) ? d_busywait : i_busywait;
    chk({v.name, ".bw_grant"}, bw_own, 1'b1);
    chk({v.name, ".bw_other"}, bw_oth, 1'b0);
    cnt = 1;
    @(negedge clk);
    while (((v.own == 2'b01) ? i_busywait : d_busywait) && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk({v.name, ".latency"}, cnt, 7);
    chk({v.name, ".rel_owner"}, owner, 2'b00);
    chk({v.name, ".rel_mcmd"}, {m_read, m_write}, 2'b00);
    chk({v.name, ".i_rdata"}, i_readdata, v.xir);
    chk({v.name, ".d_rdata"}, d_readdata, v.xdr);
    @(posedge clk); #1;
    bw_own = (v.own == 2'b01) ? i_busywait : d_busywait;
    chk({v.name, ".bw_after_rel"}, bw_own, 1'b1);
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
    chk({v.name, ".idle_owner"}, owner, 2'b00);
  endtask

  task automatic wait_owner(input bit want_none, input string nm);
    int t;
    t = 0;
    while (((owner == 2'b00) != want_none) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk({nm, ".timeout"}, 1'b1, 1'b0);
  endtask

  vec_t tbl[6];
  logic [1:0] rr_exp[4];
  logic [1:0] got;

  initial begin
    tbl[0] = mk("i_rd05", 1, 0, 0, 6'h05, 6'h00, 32'h0, 2'b01, 1, 0,
                6'h05, 32'h0, 32'h1005_0505, 32'h0);
    tbl[1] = mk("d_rd12", 0, 1, 0, 6'h00, 6'h12, 32'h0, 2'b10, 1, 0,
                6'h12, 32'h0, 32'h1005_0505, 32'h1012_1212);
    tbl[2] = mk("d_wr3F", 0, 0, 1, 6'h00, 6'h3F, 32'hA5A5_A5A5, 2'b10,
                0, 1, 6'h3F, 32'hA5A5_A5A5, 32'h1005_0505, 32'h1012_1212);
    tbl[3] = mk("d_rw07", 0, 1, 1, 6'h00, 6'h07, 32'h0000_1234, 2'b10,
                0, 1, 6'h07, 32'h0000_1234, 32'h1005_0505, 32'h1012_1212);
    tbl[4] = mk("i_rd2A", 1, 0, 0, 6'h2A, 6'h3F, 32'hFFFF_FFFF, 2'b01,
                1, 0, 6'h2A, 32'h0, 32'h102A_2A2A, 32'h1012_1212);
    tbl[5] = mk("d_rd00", 0, 1, 0, 6'h00, 6'h00, 32'h0, 2'b10, 1, 0,
                6'h00, 32'h0, 32'h102A_2A2A, 32'h1000_0000);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    rr_exp = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif

    // Reset held with requests present: everything quiet.
    i_read = 1'b1; d_read = 1'b1;
    #12;
    chk("rst.owner", owner, 2'b00);
    chk("rst.i_bw", i_busywait, 1'b0);
    chk("rst.d_bw", d_busywait, 1'b0);
    chk("rst.m_cmd", {m_read, m_write}, 2'b00);
    chk("rst.i_rdata", i_readdata, 32'h0);
    chk("rst.d_rdata", d_readdata, 32'h0);
    i_read = 1'b0; d_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(tbl[k]);

    // Reset in the middle of a dcache read.
    @(negedge clk);
    d_read = 1'b1; d_address = 6'h21;
    @(posedge clk); #1;
    chk("mid.owner_pre", owner, 2'b10);
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("mid.owner", owner, 2'b00);
    chk("mid.m_cmd", {m_read, m_write}, 2'b00);
    chk("mid.m_addr", m_address, 6'h00);
    chk("mid.d_bw", d_busywait, 1'b0);
    chk("mid.d_rdata", d_readdata, 32'h0);
    chk("mid.i_rdata", i_readdata, 32'h0);
    d_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_vec(tbl[0]);

    // Simultaneous reads: dcache first, icache after the release.
    @(negedge clk);
    i_read = 1'b1; i_address = 6'h0A;
    d_read = 1'b1; d_address = 6'h15;
    @(posedge clk); #1;
    chk("both.owner1", owner, 2'b10);
    chk("both.addr1", m_address, 6'h15);
    wait_owner(1'b1, "both.rel1");
    chk("both.d_rdata", d_readdata, 32'h1015_1515);
    chk("both.d_bw_rel", d_busywait, 1'b0);
    chk("both.i_bw_rel", i_busywait, 1'b1);
    @(posedge clk); #1;
    d_read = 1'b0;
    chk("both.idle", owner, 2'b00);
    @(posedge clk); #1;
    chk("both.owner2", owner, 2'b01);
    chk("both.addr2", m_address, 6'h0A);
    wait_owner(1'b1, "both.rel2");
    chk("both.i_rdata", i_readdata, 32'h100A_0A0A);
    chk("both.d_hold", d_readdata, 32'h1015_1515);
    i_read = 1'b0;

    // Both clients re-requesting continuously.
    @(negedge clk);
    i_read = 1'b1; i_address = 6'h01;
    d_read = 1'b1; d_address = 6'h02;
    for (int k = 0; k < 4; k++) begin
      wait_owner(1'b0, "cont.grant");
      got = owner;
      chk($sformatf("cont.grant%0d", k), got, rr_exp[k]);
      wait_owner(1'b1, "cont.rel");
    end
    i_read = 1'b0; d_read = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("cont.quiet", owner, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
